// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and access-size encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    // Same encoding the data memory uses for its size field.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner selection between fetch and data requesters
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       if_valid_i,
    input  logic       d_valid_i,
    input  logic [3:0] streak_i,
    output logic       pick_if_o,
    output logic       pick_d_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic starved;

    // Fetch only overrides data once data has won LIMIT contested grants in a row.
    assign starved   = if_valid_i && (streak_i == LIMIT);
    assign pick_d_o  = d_valid_i && !starved;
    assign pick_if_o = if_valid_i && !pick_d_o;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared memory port; optional ARB_PERF_CNT_EN stall counters
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic        d_req_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_size,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        mem_en,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] if_stall_cnt,
    output logic [31:0] d_stall_cnt
`endif
);

    localparam logic [3:0] LAT   = 4'(MEM_LAT);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e state_q;
    arb_owner_e owner_q;
    logic [3:0] cnt_q;
    logic [3:0] streak_q;
    logic [3:0] streak_d;
    logic       wr_q;

    logic slot;
    logic pick_if;
    logic pick_d;
    logic grant_if;
    logic grant_d;
    logic rsp_fire;

    // A new command may issue while idle or in the response cycle of the previous one.
    assign slot = (state_q == ARB_IDLE) || (cnt_q == LAT);

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .if_valid_i(if_req_valid),
        .d_valid_i (d_req_valid),
        .streak_i  (streak_q),
        .pick_if_o (pick_if),
        .pick_d_o  (pick_d)
    );

    // Reset gates every combinational path so nothing leaks out while it is held.
    assign grant_if = !reset && slot && pick_if;
    assign grant_d  = !reset && slot && pick_d;
    assign rsp_fire = !reset && (state_q == ARB_WAIT) && (cnt_q == LAT);

    assign if_req_ready = grant_if;
    assign d_req_ready  = grant_d;

    assign mem_en    = grant_if || grant_d;
    assign mem_rw    = grant_d && d_req_rw;
    assign mem_addr  = grant_d ? d_addr : (grant_if ? if_addr : 32'h0);
    assign mem_wdata = grant_d ? d_wdata : 32'h0;
    assign mem_size  = grant_d ? d_size : (grant_if ? SZ_WORD : SZ_BYTE);

    assign if_rsp_valid = rsp_fire && (owner_q == OWN_IF);
    assign if_rsp_data  = if_rsp_valid ? mem_rdata : 32'h0;
    assign d_rsp_valid  = rsp_fire && (owner_q == OWN_D);
    assign d_rsp_data   = (d_rsp_valid && !wr_q) ? mem_rdata : 32'h0;

    always_comb begin
        streak_d = streak_q;
        if (grant_if) begin
            streak_d = 4'd0;
        end else if (grant_d) begin
            if (!if_req_valid) begin
                streak_d = 4'd0;
            end else if (streak_q != LIMIT) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_IF;
            cnt_q    <= 4'd0;
            streak_q <= 4'd0;
            wr_q     <= 1'b0;
        end else begin
            streak_q <= streak_d;
            if (slot) begin
                if (grant_if || grant_d) begin
                    state_q <= ARB_WAIT;
                    cnt_q   <= 4'd1;
                    owner_q <= grant_d ? OWN_D : OWN_IF;
                    wr_q    <= grant_d && d_req_rw;
                end else begin
                    state_q <= ARB_IDLE;
                    cnt_q   <= 4'd0;
                end
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_stall_cnt <= 32'd0;
            d_stall_cnt  <= 32'd0;
        end else begin
            if (if_req_valid && !if_req_ready) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (d_req_valid && !d_req_ready) begin
                d_stall_cnt <= d_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (MEM_LAT=2, STARVE_LIMIT=4)
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_rw, d_rsp_valid;
    logic [31:0] d_addr, d_wdata, d_rsp_data;
    logic [1:0]  d_size;
    logic        mem_en, mem_rw;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt, d_stall_cnt;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t ifq[$];
    exp_t dq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    mem_port_arbiter #(.MEM_LAT(2), .STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_rw(d_req_rw),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
        , .if_stall_cnt(if_stall_cnt), .d_stall_cnt(d_stall_cnt)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // Memory model: read data appears two cycles after the command.
    logic [1:0]  pv = 2'b00;
    logic [31:0] pa0 = 32'h0;
    logic [31:0] pa1 = 32'h0;
    always @(posedge clock) begin
        pv  <= {pv[0], mem_en & ~mem_rw};
        pa0 <= mem_addr;
        pa1 <= pa0;
    end
    assign mem_rdata = pv[1] ? mem_val(pa1) : 32'h0BAD_0BAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_if(input logic [31:0] data, input int c);
        exp_t e;
        e.data = data;
        e.cyc  = c;
        ifq.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] data, input int c);
        exp_t e;
        e.data = data;
        e.cyc  = c;
        dq.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while ((ifq.size() != 0 || dq.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (ifq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses still pending, expected 0", ifq.size() + dq.size());
            ifq.delete();
            dq.delete();
        end
        repeat (3) tick();
    endtask

    // Monitor: pops the scoreboard on every response strobe and checks invariants.
    always @(negedge clock) begin
        chk("one_ready", {31'h0, if_req_ready & d_req_ready}, 32'h0);
        chk("ready_needs_valid",
            {31'h0, (if_req_ready & ~if_req_valid) | (d_req_ready & ~d_req_valid)}, 32'h0);
        if (if_rsp_valid) begin
            if (ifq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL if_rsp_unexpected: got if_rsp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = ifq.pop_front();
                chk("if_rsp_data", if_rsp_data, mon_e.data);
                chk("if_rsp_cycle", cyc, mon_e.cyc);
            end
        end
        if (d_rsp_valid) begin
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL d_rsp_unexpected: got d_rsp_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = dq.pop_front();
                chk("d_rsp_data", d_rsp_data, mon_e.data);
                chk("d_rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        if_req_valid = 1'b1; if_addr = 32'h0;
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_addr = 32'h1234; d_wdata = 32'h0; d_size = 2'b10;

        // Reset: valids high but nothing may be granted or driven.
        repeat (2) @(negedge clock);
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rsp_valid", {if_rsp_valid, d_rsp_valid}, 0);
        tick();
        reset = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Fetch only.
        if_req_valid = 1'b1; if_addr = 32'h0100_0000;
        @(negedge clock);
        chk("t1_if_ready", if_req_ready, 1);
        chk("t1_mem_en", mem_en, 1);
        chk("t1_mem_addr", mem_addr, 32'h0100_0000);
        chk("t1_mem_rw", mem_rw, 0);
        chk("t1_mem_size", mem_size, 2'b10);
        push_if(mem_val(32'h0100_0000), cyc + 2);
        tick();
        if_req_valid = 1'b0;
        drain();

        // Simultaneous first requests: data first, fetch in the response slot.
        if_req_valid = 1'b1; if_addr = 32'h0100_0010;
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_addr = 32'h0100_0100; d_size = 2'b10;
        @(negedge clock);
        chk("t2_d_ready", d_req_ready, 1);
        chk("t2_if_ready_T", if_req_ready, 0);
        chk("t2_mem_addr", mem_addr, 32'h0100_0100);
        push_d(mem_val(32'h0100_0100), cyc + 2);
        tick();
        d_req_valid = 1'b0;
        @(negedge clock);
        chk("t2_if_ready_T1", if_req_ready, 0);
        tick();
        @(negedge clock);
        chk("t2_if_ready_T2", if_req_ready, 1);
        push_if(mem_val(32'h0100_0010), cyc + 2);
        tick();
        if_req_valid = 1'b0;
        drain();

        // Starvation: grants D,D,D,D,IF,D with both valids held.
        if_req_valid = 1'b1; if_addr = 32'h0100_0020;
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_size = 2'b10; d_addr = 32'h0100_0200;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk("t3_if_ready", if_req_ready, (i == 4));
            chk("t3_d_ready", d_req_ready, (i != 4));
            if (i == 4) push_if(mem_val(if_addr), cyc + 2);
            else push_d(mem_val(d_addr), cyc + 2);
            tick();
            if (i != 4) d_addr = d_addr + 32'd4;
            @(negedge clock);
            chk("t3_gap_ready", {if_req_ready, d_req_ready}, 0);
            if (i == 5) begin
                if_req_valid = 1'b0;
                d_req_valid = 1'b0;
            end
            tick();
        end
        drain();

        // Store: response data must be zero.
        d_req_valid = 1'b1; d_req_rw = 1'b1; d_size = 2'b01;
        d_wdata = 32'h0000_BEEF; d_addr = 32'h0100_0202;
        @(negedge clock);
        chk("t4_d_ready", d_req_ready, 1);
        chk("t4_mem_rw", mem_rw, 1);
        chk("t4_mem_size", mem_size, 2'b01);
        chk("t4_mem_wdata", mem_wdata, 32'h0000_BEEF);
        chk("t4_mem_addr", mem_addr, 32'h0100_0202);
        push_d(32'h0, cyc + 2);
        tick();
        d_req_valid = 1'b0; d_req_rw = 1'b0; d_size = 2'b10;
        drain();

        // Reset one cycle after a grant drops that response.
        if_req_valid = 1'b1; if_addr = 32'h0100_0040;
        @(negedge clock);
        chk("t5_if_ready", if_req_ready, 1);
        tick();
        if_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("t5_rst_mem_en", mem_en, 0);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        if_req_valid = 1'b1; if_addr = 32'h0100_0044;
        @(negedge clock);
        chk("t5_post_if_ready", if_req_ready, 1);
        chk("t5_post_mem_addr", mem_addr, 32'h0100_0044);
        push_if(mem_val(32'h0100_0044), cyc + 2);
        tick();
        if_req_valid = 1'b0;
        drain();

        // Fetch held four cycles behind two data requests.
        if_req_valid = 1'b1; if_addr = 32'h0100_0080;
        d_req_valid = 1'b1; d_req_rw = 1'b0; d_addr = 32'h0100_0300; d_size = 2'b10;
        @(negedge clock);
        chk("t6_d_ready_0", d_req_ready, 1);
        chk("t6_if_ready_0", if_req_ready, 0);
        push_d(mem_val(32'h0100_0300), cyc + 2);
        tick();
        d_req_valid = 1'b0;
        @(negedge clock);
        chk("t6_if_ready_1", if_req_ready, 0);
        tick();
        d_req_valid = 1'b1; d_addr = 32'h0100_0304;
        @(negedge clock);
        chk("t6_d_ready_2", d_req_ready, 1);
        chk("t6_if_ready_2", if_req_ready, 0);
        push_d(mem_val(32'h0100_0304), cyc + 2);
        tick();
        d_req_valid = 1'b0;
        @(negedge clock);
        chk("t6_if_ready_3", if_req_ready, 0);
        tick();
        @(negedge clock);
        chk("t6_if_ready_4", if_req_ready, 1);
        push_if(mem_val(32'h0100_0080), cyc + 2);
        tick();
        if_req_valid = 1'b0;
        drain();
`ifdef ARB_PERF_CNT_EN
        chk("t6_if_stall_cnt", if_stall_cnt, 32'd4);
        chk("t6_d_stall_cnt", d_stall_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
